// File: rtl/div_pkg.sv
// Shared constants, state encoding and operand helpers for the iterative divider.
// The magnitude helper is only meaningful when DIV_SIGNED_EN is defined.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    localparam logic [DIV_WIDTH-1:0] DIV_INT_MIN = 32'h8000_0000;
    localparam logic [DIV_CNT_W-1:0] DIV_CNT_ONE = {{(DIV_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_CNT_W-1:0] DIV_CNT_LAST = DIV_CNT_W'(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Two's-complement magnitude; INT_MIN maps onto itself, which is correct as unsigned.
    function automatic logic [DIV_WIDTH-1:0] div_mag(input logic [DIV_WIDTH-1:0] v);
        logic [DIV_WIDTH-1:0] m;
        if (v[DIV_WIDTH-1]) begin
            m = -v;
        end else begin
            m = v;
        end
        return m;
    endfunction

endpackage

// File: rtl/div_if.sv
// Start/operand/result bundle between the requester (master) and div_unit (slave).
interface div_if
    import div_pkg::*;
();

    logic                 enable;
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
    logic [DIV_WIDTH-1:0] result;
    logic                 ready;
    logic                 exception;

    modport master (output enable, dividend, divisor, input result, ready, exception);
    modport slave  (input enable, dividend, divisor, output result, ready, exception);

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and try to subtract.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem_i,
    input  logic                 bit_i,
    input  logic [DIV_WIDTH-1:0] dvs_i,
    output logic [DIV_WIDTH-1:0] rem_o,
    output logic                 q_o
);

    logic [DIV_WIDTH:0] shifted_s;
    logic [DIV_WIDTH:0] diff_s;

    // Trial subtraction on W+1 bits since the shifted remainder can exceed W bits.
    always_comb begin
        shifted_s = {rem_i, bit_i};
        diff_s    = shifted_s - {1'b0, dvs_i};
        if (shifted_s >= {1'b0, dvs_i}) begin
            rem_o = diff_s[DIV_WIDTH-1:0];
            q_o   = 1'b1;
        end else begin
            rem_o = shifted_s[DIV_WIDTH-1:0];
            q_o   = 1'b0;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit divider: one quotient bit per cycle, divide-by-zero/overflow fast path.
// Define DIV_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module div_unit
    import div_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    div_if.slave bus
);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] rem_q, rem_d;
    logic [DIV_WIDTH-1:0] quo_q, quo_d;
    logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
    logic                 neg_q, neg_d;
    logic                 dz_q, dz_d;
    logic                 ovf_q, ovf_d;
    logic [DIV_WIDTH-1:0] result_q, result_d;
    logic                 exc_q, exc_d;
    logic                 ready_q, ready_d;

    logic                 start_s;
    logic [DIV_WIDTH-1:0] step_rem_s;
    logic                 step_bit_s;
    logic [DIV_WIDTH-1:0] a_mag_s, b_mag_s;
    logic                 neg_s, ovf_s, dz_s;

    div_step u_step (
        .rem_i (rem_q),
        .bit_i (quo_q[DIV_WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem_s),
        .q_o   (step_bit_s)
    );

    // Operand conditioning at start: magnitudes, quotient sign and fast-path flags.
    always_comb begin
        dz_s = (bus.divisor == {DIV_WIDTH{1'b0}});
`ifdef DIV_SIGNED_EN
        a_mag_s = div_mag(bus.dividend);
        b_mag_s = div_mag(bus.divisor);
        neg_s   = bus.dividend[DIV_WIDTH-1] ^ bus.divisor[DIV_WIDTH-1];
        ovf_s   = (bus.dividend == DIV_INT_MIN) && (bus.divisor == {DIV_WIDTH{1'b1}});
`else
        a_mag_s = bus.dividend;
        b_mag_s = bus.divisor;
        neg_s   = 1'b0;
        ovf_s   = 1'b0;
`endif
    end

    // FSM, iteration counter and output-register next state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        ready_d  = 1'b0;
        start_s  = bus.enable && ((state_q == IDLE) || (state_q == DONE));
        case (state_q)
            IDLE, DONE: begin
                if (start_s) begin
                    rem_d   = {DIV_WIDTH{1'b0}};
                    quo_d   = a_mag_s;
                    dvs_d   = b_mag_s;
                    neg_d   = neg_s;
                    dz_d    = dz_s;
                    ovf_d   = ovf_s;
                    state_d = RUN;
                    // Fast path skips straight to the completion count.
                    if (dz_s || ovf_s) begin
                        cnt_d = DIV_CNT_LAST;
                    end else begin
                        cnt_d = {DIV_CNT_W{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == DIV_CNT_LAST) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    if (dz_q) begin
                        result_d = {DIV_WIDTH{1'b0}};
                        exc_d    = 1'b1;
                    end else if (ovf_q) begin
                        result_d = DIV_INT_MIN;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = neg_q ? -quo_q : quo_q;
                        exc_d    = 1'b0;
                    end
                end else begin
                    rem_d = step_rem_s;
                    quo_d = {quo_q[DIV_WIDTH-2:0], step_bit_s};
                    cnt_d = cnt_q + DIV_CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= {DIV_CNT_W{1'b0}};
            rem_q    <= {DIV_WIDTH{1'b0}};
            quo_q    <= {DIV_WIDTH{1'b0}};
            dvs_q    <= {DIV_WIDTH{1'b0}};
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= {DIV_WIDTH{1'b0}};
            exc_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.exception = exc_q;
    assign bus.ready     = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit; expectations follow DIV_SIGNED_EN when it is defined.
module tb_div_unit;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    div_if bus ();

    div_unit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse enable for one edge, scramble the buses, then count edges until ready.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clock);
        bus.enable   = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clock);
        bus.enable   = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (bus.ready) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want %h", bus.result, 32'h0); end
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.ready); end
        checks++;
        if (bus.exception !== 1'b0) begin errors++; $display("FAIL reset_exc got %b want 0", bus.exception); end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        do_op(32'd10, 32'd2, lat);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL basic_lat got %0d want 33", lat); end
        checks++;
        if (bus.result !== 32'd5) begin errors++; $display("FAIL basic_result got %h want %h", bus.result, 32'd5); end
        checks++;
        if (bus.exception !== 1'b0) begin errors++; $display("FAIL basic_exc got %b want 0", bus.exception); end
        @(negedge clock);
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b want 0", bus.ready); end
    endtask

    task automatic test_signed();
        int lat;
        logic [31:0] exp1, exp2;
`ifdef DIV_SIGNED_EN
        exp1 = 32'hFFFF_FFFD;
        exp2 = 32'hFFFF_FFF2;
`else
        exp1 = 32'h7FFF_FFFC;
        exp2 = 32'h0000_0000;
`endif
        do_op(32'hFFFF_FFF9, 32'd2, lat);
        checks++;
        if (bus.result !== exp1 || lat !== 33) begin errors++; $display("FAIL neg7_div2 got %h lat %0d want %h lat 33", bus.result, lat, exp1); end
        checks++;
        if (bus.exception !== 1'b0) begin errors++; $display("FAIL neg7_exc got %b want 0", bus.exception); end
        do_op(32'd100, 32'hFFFF_FFF9, lat);
        checks++;
        if (bus.result !== exp2 || lat !== 33) begin errors++; $display("FAIL d100_neg7 got %h lat %0d want %h lat 33", bus.result, lat, exp2); end
        checks++;
        if (bus.exception !== 1'b0) begin errors++; $display("FAIL d100_exc got %b want 0", bus.exception); end
    endtask

    task automatic test_overflow();
        int lat;
        logic [31:0] exp_res;
        logic        exp_exc;
        int          exp_lat;
`ifdef DIV_SIGNED_EN
        exp_res = 32'h8000_0000;
        exp_exc = 1'b1;
        exp_lat = 1;
`else
        exp_res = 32'h0000_0000;
        exp_exc = 1'b0;
        exp_lat = 33;
`endif
        do_op(32'h8000_0000, 32'hFFFF_FFFF, lat);
        checks++;
        if (lat !== exp_lat) begin errors++; $display("FAIL ovf_lat got %0d want %0d", lat, exp_lat); end
        checks++;
        if (bus.result !== exp_res) begin errors++; $display("FAIL ovf_result got %h want %h", bus.result, exp_res); end
        checks++;
        if (bus.exception !== exp_exc) begin errors++; $display("FAIL ovf_exc got %b want %b", bus.exception, exp_exc); end
    endtask

    task automatic test_div_zero();
        int lat;
        do_op(32'd7, 32'd0, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL dz_lat got %0d want 1", lat); end
        checks++;
        if (bus.result !== 32'h0) begin errors++; $display("FAIL dz_result got %h want %h", bus.result, 32'h0); end
        checks++;
        if (bus.exception !== 1'b1) begin errors++; $display("FAIL dz_exc got %b want 1", bus.exception); end
        do_op(32'd9, 32'd3, lat);
        checks++;
        if (bus.result !== 32'd3 || lat !== 33) begin errors++; $display("FAIL dz_next got %h lat %0d want %h lat 33", bus.result, lat, 32'd3); end
        checks++;
        if (bus.exception !== 1'b0) begin errors++; $display("FAIL dz_next_exc got %b want 0", bus.exception); end
    endtask

    task automatic test_enable_ignored();
        int first;
        int pulses;
        @(negedge clock);
        bus.enable   = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd10;
        @(negedge clock);
        bus.enable   = 1'b0;
        first  = -1;
        pulses = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clock);
            if (bus.ready) begin
                pulses++;
                if (first < 0) first = k;
            end
            if (k == 5) begin
                checks++;
                if (bus.result !== 32'd3) begin errors++; $display("FAIL hold_result got %h want %h", bus.result, 32'd3); end
            end
            if (k == 9) begin
                bus.enable   = 1'b1;
                bus.dividend = 32'd50;
                bus.divisor  = 32'd5;
            end else begin
                bus.enable = 1'b0;
            end
            if (k == 33) begin
                checks++;
                if (bus.result !== 32'd10) begin errors++; $display("FAIL ign_result got %h want %h", bus.result, 32'd10); end
            end
        end
        checks++;
        if (first !== 33) begin errors++; $display("FAIL ign_lat got %0d want 33", first); end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL ign_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(32'd6, 32'd3, lat);
        checks++;
        if (bus.result !== 32'd2 || lat !== 33) begin errors++; $display("FAIL b2b_first got %h lat %0d want %h lat 33", bus.result, lat, 32'd2); end
        bus.enable   = 1'b1;
        bus.dividend = 32'd21;
        bus.divisor  = 32'd7;
        @(negedge clock);
        bus.enable = 1'b0;
        checks++;
        if (bus.ready !== 1'b0 || bus.result !== 32'd2) begin errors++; $display("FAIL b2b_hold got rdy %b res %h want rdy 0 res %h", bus.ready, bus.result, 32'd2); end
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (bus.ready) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (bus.result !== 32'd3 || lat !== 33) begin errors++; $display("FAIL b2b_second got %h lat %0d want %h lat 33", bus.result, lat, 32'd3); end
    endtask

    task automatic test_reset_abort();
        int pulses;
        int lat;
        @(negedge clock);
        bus.enable   = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd7;
        @(negedge clock);
        bus.enable = 1'b0;
        repeat (14) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        checks++;
        if (bus.result !== 32'h0 || bus.ready !== 1'b0 || bus.exception !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear got res %h rdy %b exc %b want 0 0 0", bus.result, bus.ready, bus.exception);
        end
        // Reset asserted together with a start: the start must be dropped.
        @(negedge clock);
        reset_n      = 1'b0;
        bus.enable   = 1'b1;
        bus.dividend = 32'd8;
        bus.divisor  = 32'd2;
        @(negedge clock);
        reset_n    = 1'b1;
        bus.enable = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (bus.ready) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL abort_no_ready got %0d want 0", pulses); end
        do_op(32'd20, 32'd4, lat);
        checks++;
        if (bus.result !== 32'd5 || lat !== 33) begin errors++; $display("FAIL abort_next got %h lat %0d want %h lat 33", bus.result, lat, 32'd5); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        bus.enable   = 1'b0;
        bus.dividend = 32'h0;
        bus.divisor  = 32'h0;
        test_reset();
        test_basic();
        test_signed();
        test_overflow();
        test_div_zero();
        test_enable_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
